mem_bus_ctrl: RTL and testbench

//  Memory bus controller between the 6502 core's external bus and the ROM/RAM arrays in top.mem.

---
 rtl/mem_bus_ctrl_if.sv | 21 ++
 rtl/mem_bus_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side bus of the memory controller: request, direction, address, data, and ack/error response.
// The controller uses the slave modport; the CPU (or bench) uses the master modport.
interface mem_bus_ctrl_if;
    logic        cpu_req;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        bus_err;

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, bus_err
    );

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, bus_err
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// 6502 bus to RAM/ROM controller: region decode, per-region wait states, one-cycle ack, illegal-access flag.
// Defining MEM_TRACE_EN adds a FIFO that records every committed RAM write as {addr,data}.
module mem_bus_ctrl #(
    parameter int RAM_AW      = 12,
    parameter int ROM_AW      = 12,
    parameter int RAM_WAIT    = 0,
    parameter int ROM_WAIT    = 1,
    parameter int TRACE_DEPTH = 8
) (
    input  logic              ph2,
    input  logic              reset,
    mem_bus_ctrl_if.slave     bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    input  logic              trace_pop,
    output logic              trace_valid,
    output logic [15:0]       trace_addr,
    output logic [7:0]        trace_data,
    output logic              trace_ovf
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {RG_RAM, RG_ROM, RG_UNM} region_t;

    localparam logic [16:0] RAM_TOP  = 17'(1 << RAM_AW);
    localparam logic [16:0] ROM_BASE = 17'(65536 - (1 << ROM_AW));

    state_t             r_state, w_next_state;
    region_t            r_region, w_region, w_acc_region;
    logic [3:0]         r_cnt, w_wait;
    logic [15:0]        r_addr, w_acc_addr;
    logic               r_rw;
    logic [7:0]         r_wdata;
    logic [RAM_AW-1:0]  r_ram_addr;
    logic [ROM_AW-1:0]  r_rom_addr;

    always_comb begin
        w_region = RG_UNM;
        if ({1'b0, bus.cpu_addr} < RAM_TOP)
            w_region = RG_RAM;
        else if ({1'b0, bus.cpu_addr} >= ROM_BASE)
            w_region = RG_ROM;
    end

    always_comb begin
        w_wait = 4'd0;
        case (w_region)
            RG_RAM:  w_wait = 4'(RAM_WAIT);
            RG_ROM:  w_wait = 4'(ROM_WAIT);
            default: w_wait = 4'd0;
        endcase
    end

    // Entering ACCESS straight from IDLE must use the live bus, otherwise the latched copy.
    assign w_acc_addr   = (r_state == S_IDLE) ? bus.cpu_addr : r_addr;
    assign w_acc_region = (r_state == S_IDLE) ? w_region     : r_region;

    always_comb begin
        w_next_state  = r_state;
        bus.cpu_ack   = 1'b0;
        bus.bus_err   = 1'b0;
        bus.cpu_rdata = 8'h00;
        ram_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req)
                    w_next_state = (w_wait != 4'd0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                if (r_cnt == 4'd1)
                    w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                ram_we       = (r_region == RG_RAM) && !r_rw;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                bus.cpu_ack  = 1'b1;
                bus.bus_err  = (r_region == RG_UNM) || ((r_region == RG_ROM) && !r_rw);
                if (r_rw) begin
                    case (r_region)
                        RG_RAM:  bus.cpu_rdata = ram_rdata;
                        RG_ROM:  bus.cpu_rdata = rom_rdata;
                        default: bus.cpu_rdata = 8'hFF;
                    endcase
                end
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge ph2) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 16'h0000;
            r_rw       <= 1'b0;
            r_wdata    <= 8'h00;
            r_region   <= RG_RAM;
            r_ram_addr <= '0;
            r_rom_addr <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        r_addr   <= bus.cpu_addr;
                        r_rw     <= bus.cpu_rw;
                        r_wdata  <= bus.cpu_wdata;
                        r_region <= w_region;
                        r_cnt    <= w_wait;
                    end
                end
                S_WAIT:  r_cnt <= r_cnt - 4'd1;
                default: ;
            endcase
            // Array addresses only move when entering ACCESS and hold otherwise.
            if (w_next_state == S_ACCESS) begin
                if (w_acc_region == RG_RAM)
                    r_ram_addr <= w_acc_addr[RAM_AW-1:0];
                if (w_acc_region == RG_ROM)
                    r_rom_addr <= w_acc_addr[ROM_AW-1:0];
            end
        end
    end

    assign ram_addr  = r_ram_addr;
    assign rom_addr  = r_rom_addr;
    assign ram_wdata = r_wdata;

    logic w_unused_acc;
    assign w_unused_acc = ^w_acc_addr;

`ifdef MEM_TRACE_EN
    localparam int PW = $clog2(TRACE_DEPTH);

    logic [23:0] r_trace_mem [TRACE_DEPTH];
    logic [PW:0] r_wr_ptr, r_rd_ptr;
    logic        r_ovf;
    logic        w_empty, w_full, w_pop, w_push_ok;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_pop     = trace_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = ram_we && (!w_full || w_pop);

    always_ff @(posedge ph2) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            else if (ram_we)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge ph2) begin
        if (w_push_ok)
            r_trace_mem[r_wr_ptr[PW-1:0]] <= {r_addr, r_wdata};
    end

    assign trace_valid = !w_empty;
    assign trace_addr  = w_empty ? 16'h0000 : r_trace_mem[r_rd_ptr[PW-1:0]][23:8];
    assign trace_data  = w_empty ? 8'h00    : r_trace_mem[r_rd_ptr[PW-1:0]][7:0];
    assign trace_ovf   = r_ovf;
`else
    logic w_unused_trace;
    assign w_unused_trace = ^{trace_pop, r_addr};

    assign trace_valid = 1'b0;
    assign trace_addr  = 16'h0000;
    assign trace_data  = 8'h00;
    assign trace_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed scenarios plus random accesses checked against a region/latency model.
// Physical RAM/ROM arrays live here and respond one cycle after their address.
module tb_mem_bus_ctrl;
    localparam int RAM_AW      = 12;
    localparam int ROM_AW      = 12;
    localparam int RAM_WAIT    = 0;
    localparam int ROM_WAIT    = 1;
    localparam int TRACE_DEPTH = 8;
    localparam int ROM_BASE    = 65536 - (1 << ROM_AW);

    logic              ph2 = 1'b0;
    logic              reset = 1'b1;
    logic              preload = 1'b0;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_rdata;
    logic              trace_pop = 1'b0;
    logic              trace_valid;
    logic [15:0]       trace_addr;
    logic [7:0]        trace_data;
    logic              trace_ovf;

    mem_bus_ctrl_if bus();

    mem_bus_ctrl #(
        .RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .RAM_WAIT(RAM_WAIT),
        .ROM_WAIT(ROM_WAIT), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .ph2(ph2), .reset(reset), .bus(bus),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .trace_pop(trace_pop), .trace_valid(trace_valid), .trace_addr(trace_addr),
        .trace_data(trace_data), .trace_ovf(trace_ovf)
    );

    always #5 ph2 = ~ph2;

    function automatic logic [7:0] ram_init(int i);
        if (i == 3)   return 8'h22;
        if (i == 291) return 8'hAA;
        return 8'((i * 13 + 5) ^ (i >> 3));
    endfunction

    function automatic logic [7:0] rom_fn(int i);
        if (i == 4092) return 8'h00;
        if (i == 4093) return 8'hF0;
        return 8'((i * 7 + 3) ^ (i >> 4));
    endfunction

    logic [7:0]         ram_arr [4096];
    int                 we_count = 0;
    logic [RAM_AW-1:0]  we_last_addr = '0;

    always @(posedge ph2) begin
        ram_rdata <= ram_arr[ram_addr];
        rom_rdata <= rom_fn(int'(rom_addr));
        if (preload) begin
            for (int i = 0; i < 4096; i++) ram_arr[i] <= ram_init(i);
        end else if (ram_we) begin
            ram_arr[ram_addr] <= ram_wdata;
            we_count          <= we_count + 1;
            we_last_addr      <= ram_addr;
        end
    end

    // Reference model: byte contents, trace queue and overflow flag.
    logic [7:0]  m_ram [4096];
    logic [23:0] tq [$];
    bit          exp_ovf;
    int          errors = 0;
    int          checks = 0;

    task automatic model_reset();
        tq.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic model_apply(input logic rw, input logic [15:0] a, input logic [7:0] d,
                               output int lat, output logic [7:0] rd, output logic er);
        int ai;
        ai = int'(a);
        rd = 8'h00;
        if (ai < (1 << RAM_AW)) begin
            lat = RAM_WAIT + 2;
            er  = 1'b0;
            if (rw) rd = m_ram[ai];
            else begin
                m_ram[ai] = d;
                if (tq.size() < TRACE_DEPTH) tq.push_back({a, d});
                else exp_ovf = 1'b1;
            end
        end else if (ai >= ROM_BASE) begin
            lat = ROM_WAIT + 2;
            er  = !rw;
            if (rw) rd = rom_fn(ai - ROM_BASE);
        end else begin
            lat = 2;
            er  = 1'b1;
            if (rw) rd = 8'hFF;
        end
    endtask

    task automatic do_access(input logic rw, input logic [15:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rd, output logic er);
        bus.cpu_req = 1'b1; bus.cpu_rw = rw; bus.cpu_addr = a; bus.cpu_wdata = d;
        lat = -1; rd = 8'h00; er = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge ph2); @(negedge ph2);
            if (bus.cpu_ack) begin
                lat = k; rd = bus.cpu_rdata; er = bus.bus_err;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        int w0;
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h0004; bus.cpu_wdata = 8'h99;
        w0 = we_count;
        repeat (3) @(negedge ph2);
        checks++;
        if ({bus.cpu_ack, bus.bus_err, ram_we, trace_valid, trace_ovf} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.cpu_ack, bus.bus_err, ram_we, trace_valid, trace_ovf});
        end
        checks++;
        if ({bus.cpu_rdata, ram_wdata, ram_addr, rom_addr, trace_addr, trace_data} !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {bus.cpu_rdata, ram_wdata, ram_addr, rom_addr, trace_addr, trace_data});
        end
        checks++;
        if (we_count !== w0) begin
            errors++; $display("FAIL reset_no_we: got %0d writes expected %0d", we_count, w0);
        end
        bus.cpu_req = 1'b0;
        reset = 1'b0;
        model_reset();
        @(negedge ph2);
    endtask

    task automatic test_reset_vector();
        int lat, elat; logic [7:0] rd, erd; logic er, eer;
        logic [7:0] want [2];
        want[0] = 8'h00; want[1] = 8'hF0;
        for (int i = 0; i < 2; i++) begin
            @(negedge ph2);
            model_apply(1'b1, 16'hFFFC + 16'(i), 8'h00, elat, erd, eer);
            do_access(1'b1, 16'hFFFC + 16'(i), 8'h00, lat, rd, er);
            checks++;
            if (rd !== want[i] || lat !== 3 || er !== 1'b0) begin
                errors++; $display("FAIL reset_vector[%0d]: got rd=%h lat=%0d err=%b expected rd=%h lat=3 err=0", i, rd, lat, er, want[i]);
            end
        end
    endtask

    task automatic test_ram_rw();
        int lat, elat, w0; logic [7:0] rd, erd; logic er, eer;
        w0 = we_count;
        @(negedge ph2);
        model_apply(1'b0, 16'h0004, 8'h75, elat, erd, eer);
        do_access(1'b0, 16'h0004, 8'h75, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0) begin
            errors++; $display("FAIL ram_write: got lat=%0d err=%b expected lat=2 err=0", lat, er);
        end
        @(negedge ph2);
        checks++;
        if (we_count !== w0 + 1 || we_last_addr !== 12'd4) begin
            errors++; $display("FAIL ram_we_pulse: got count=%0d addr=%0d expected count=%0d addr=4", we_count - w0, we_last_addr, 1);
        end
        model_apply(1'b1, 16'h0004, 8'h00, elat, erd, eer);
        do_access(1'b1, 16'h0004, 8'h00, lat, rd, er);
        checks++;
        if (rd !== 8'h75 || lat !== 2 || er !== 1'b0) begin
            errors++; $display("FAIL ram_readback: got rd=%h lat=%0d err=%b expected rd=75 lat=2 err=0", rd, lat, er);
        end
    endtask

    task automatic test_illegal();
        int lat, elat, w0; logic [7:0] rd, erd; logic er, eer;
        w0 = we_count;
        @(negedge ph2);
        model_apply(1'b0, 16'hF123, 8'h55, elat, erd, eer);
        do_access(1'b0, 16'hF123, 8'h55, lat, rd, er);
        checks++;
        if (er !== 1'b1 || lat !== 3 || we_count !== w0) begin
            errors++; $display("FAIL rom_write: got err=%b lat=%0d we=%0d expected err=1 lat=3 we=0", er, lat, we_count - w0);
        end
        @(negedge ph2);
        do_access(1'b1, 16'h8000, 8'h00, lat, rd, er);
        checks++;
        if (rd !== 8'hFF || er !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL unmapped_read: got rd=%h err=%b lat=%0d expected rd=ff err=1 lat=2", rd, er, lat);
        end
        @(negedge ph2);
        do_access(1'b0, 16'h8000, 8'h12, lat, rd, er);
        checks++;
        if (er !== 1'b1 || lat !== 2 || we_count !== w0) begin
            errors++; $display("FAIL unmapped_write: got err=%b lat=%0d we=%0d expected err=1 lat=2 we=0", er, lat, we_count - w0);
        end
        @(negedge ph2);
        model_apply(1'b1, 16'hF123, 8'h00, elat, erd, eer);
        do_access(1'b1, 16'hF123, 8'h00, lat, rd, er);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++; $display("FAIL rom_unchanged: got rd=%h err=%b expected rd=%h err=0", rd, er, erd);
        end
    endtask

    task automatic test_reset_mid();
        int lat, elat, acks; logic [7:0] rd, erd; logic er, eer;
        @(negedge ph2);
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'hFFFE;
        @(negedge ph2);
        reset = 1'b1; bus.cpu_req = 1'b0;
        @(negedge ph2);
        checks++;
        if ({bus.cpu_ack, bus.bus_err, ram_we, bus.cpu_rdata, ram_addr, rom_addr, ram_wdata} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h expected 0", {bus.cpu_ack, bus.bus_err, ram_we, bus.cpu_rdata, ram_addr, rom_addr, ram_wdata});
        end
        reset = 1'b0;
        model_reset();
        acks = 0;
        repeat (4) begin
            @(negedge ph2);
            if (bus.cpu_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL reset_mid_no_ack: got %0d acks expected 0", acks);
        end
        model_apply(1'b1, 16'h0003, 8'h00, elat, erd, eer);
        do_access(1'b1, 16'h0003, 8'h00, lat, rd, er);
        checks++;
        if (rd !== 8'h22 || lat !== elat || er !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ram_read: got rd=%h lat=%0d expected rd=22 lat=%0d", rd, lat, elat);
        end
    endtask

    task automatic test_req_drop();
        int lat, elat; logic [7:0] erd; logic eer;
        @(negedge ph2);
        model_apply(1'b0, 16'h0123, 8'h00, elat, erd, eer);
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h0123; bus.cpu_wdata = 8'h00;
        @(negedge ph2);
        bus.cpu_req = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'hEE;
        lat = bus.cpu_ack ? 1 : -1;
        for (int k = 2; k <= 20 && lat < 0; k++) begin
            @(negedge ph2);
            if (bus.cpu_ack) lat = k;
        end
        checks++;
        if (lat !== elat) begin
            errors++; $display("FAIL req_drop_ack: got lat=%0d expected %0d", lat, elat);
        end
        @(negedge ph2);
        checks++;
        if (ram_arr[291] !== 8'h00) begin
            errors++; $display("FAIL req_drop_commit: got RAM[291]=%h expected 00", ram_arr[291]);
        end
    endtask

    task automatic test_addr_change();
        int lat, elat, w0; logic [7:0] erd; logic eer;
        w0 = we_count;
        @(negedge ph2);
        model_apply(1'b1, 16'h0010, 8'h00, elat, erd, eer);
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h0010;
        @(negedge ph2);
        bus.cpu_addr = 16'h8000; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'h3C;
        @(negedge ph2);
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== erd || bus.bus_err !== 1'b0 || we_count !== w0) begin
            errors++; $display("FAIL addr_change: got ack=%b rd=%h err=%b we=%0d expected ack=1 rd=%h err=0 we=0",
                               bus.cpu_ack, bus.cpu_rdata, bus.bus_err, we_count - w0, erd);
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, elat; logic [7:0] rd, erd; logic er, eer;
        @(negedge ph2);
        model_apply(1'b1, 16'h0020, 8'h00, elat, erd, eer);
        do_access(1'b1, 16'h0020, 8'h00, lat, rd, er);
        model_apply(1'b1, 16'h0021, 8'h00, elat, erd, eer);
        do_access(1'b1, 16'h0021, 8'h00, lat, rd, er);
        checks++;
        if (lat !== elat + 1 || rd !== erd) begin
            errors++; $display("FAIL b2b_ram: got lat=%0d rd=%h expected lat=%0d rd=%h", lat, rd, elat + 1, erd);
        end
        model_apply(1'b1, 16'hF200, 8'h00, elat, erd, eer);
        do_access(1'b1, 16'hF200, 8'h00, lat, rd, er);
        checks++;
        if (lat !== elat + 1 || rd !== erd) begin
            errors++; $display("FAIL b2b_rom: got lat=%0d rd=%h expected lat=%0d rd=%h", lat, rd, elat + 1, erd);
        end
        @(negedge ph2);
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            errors++; $display("FAIL ack_width: got ack=%b expected 0", bus.cpu_ack);
        end
    endtask

    task automatic test_random();
        int lat, elat, rg; logic [7:0] rd, erd, d; logic er, eer, rw; logic [15:0] a;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(1, 2)) @(negedge ph2);
            rg = $urandom_range(0, 2);
            if (rg == 0)      a = 16'($urandom_range(0, (1 << RAM_AW) - 1));
            else if (rg == 1) a = 16'($urandom_range(ROM_BASE, 65535));
            else              a = 16'($urandom_range(1 << RAM_AW, ROM_BASE - 1));
            rw = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            model_apply(rw, a, d, elat, erd, eer);
            do_access(rw, a, d, lat, rd, er);
            checks++;
            if (lat !== elat || er !== eer || (rw && rd !== erd)) begin
                errors++; $display("FAIL random[%0d] a=%h rw=%b: got lat=%0d err=%b rd=%h expected lat=%0d err=%b rd=%h",
                                   n, a, rw, lat, er, rd, elat, eer, erd);
            end
        end
    endtask

`ifdef MEM_TRACE_EN
    task automatic test_trace();
        int lat, elat; logic [7:0] rd, erd, d; logic er, eer; logic [15:0] a; logic [23:0] e;
        for (int n = 0; n < 9; n++) begin
            @(negedge ph2);
            a = 16'($urandom_range(32, 4000));
            d = 8'($urandom_range(0, 255));
            model_apply(1'b0, a, d, elat, erd, eer);
            do_access(1'b0, a, d, lat, rd, er);
        end
        @(negedge ph2);
        checks++;
        if (trace_ovf !== exp_ovf) begin
            errors++; $display("FAIL trace_ovf: got %b expected %b", trace_ovf, exp_ovf);
        end
        for (int i = 0; i < 8; i++) begin
            e = tq.pop_front();
            checks++;
            if (trace_valid !== 1'b1 || {trace_addr, trace_data} !== e) begin
                errors++; $display("FAIL trace_pop[%0d]: got v=%b %h expected v=1 %h", i, trace_valid, {trace_addr, trace_data}, e);
            end
            trace_pop = 1'b1;
            @(negedge ph2);
            trace_pop = 1'b0;
        end
        checks++;
        if (trace_valid !== 1'b0) begin
            errors++; $display("FAIL trace_empty: got valid=%b expected 0", trace_valid);
        end
        trace_pop = 1'b1;
        @(negedge ph2);
        trace_pop = 1'b0;
        checks++;
        if (trace_valid !== 1'b0 || trace_ovf !== 1'b1) begin
            errors++; $display("FAIL trace_pop_empty: got valid=%b ovf=%b expected valid=0 ovf=1", trace_valid, trace_ovf);
        end
    endtask
`else
    task automatic test_trace();
        int lat, elat; logic [7:0] rd, erd; logic er, eer;
        for (int n = 0; n < 2; n++) begin
            @(negedge ph2);
            model_apply(1'b0, 16'h0040 + 16'(n), 8'h5A, elat, erd, eer);
            do_access(1'b0, 16'h0040 + 16'(n), 8'h5A, lat, rd, er);
        end
        trace_pop = 1'b1;
        @(negedge ph2);
        checks++;
        if ({trace_valid, trace_ovf, trace_addr, trace_data} !== '0) begin
            errors++; $display("FAIL trace_tied: got %h expected 0", {trace_valid, trace_ovf, trace_addr, trace_data});
        end
        trace_pop = 1'b0;
    endtask
`endif

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
        for (int i = 0; i < 4096; i++) m_ram[i] = ram_init(i);
        @(negedge ph2);
        preload = 1'b1;
        @(negedge ph2);
        preload = 1'b0;
        test_reset();
        test_trace();
        test_reset_vector();
        test_ram_rw();
        test_illegal();
        test_reset_mid();
        test_req_drop();
        test_addr_change();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
